// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the default operand width.
package serial_subtractor_pkg;

  localparam int SS_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, bout is the borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with start/busy/done.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fs_d, fs_bout;
  logic [WIDTH-1:0] diff_shifted;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // New difference bit enters at the MSB; after WIDTH shifts the word is aligned.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign diff_shifted = fs_d;
    end else begin : g_shift_wn
      assign diff_shifted = {fs_d, diff_sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      diff_q    <= '0;
      bin_q     <= 1'b0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      diff_q    <= diff_d;
      bin_q     <= bin_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    diff_d    = diff_q;
    bin_d     = bin_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    ovf_d     = ovf_q;
`endif
    if (state_q == ST_IDLE && start) begin
      a_sh_d    = a;
      b_sh_d    = b;
      diff_sh_d = '0;
      bin_d     = 1'b0;
      cnt_d     = '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d   = a[WIDTH-1];
      b_msb_d   = b[WIDTH-1];
`endif
    end else if (state_q == ST_RUN) begin
      a_sh_d    = a_sh_q >> 1;
      b_sh_d    = b_sh_q >> 1;
      diff_sh_d = diff_shifted;
      bin_d     = fs_bout;
      cnt_d     = cnt_q + CNT_W'(1);
      // Result registers load only on the final bit, so they hold during RUN.
      if (cnt_q == CNT_LAST) begin
        diff_d   = diff_shifted;
        borrow_d = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
      end
    end
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_DONE);
    diff   = diff_q;
    borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    overflow = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Overflow checks are active when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, borrow8, busy1, done1, borrow1;
  logic [7:0] diff8;
  logic [0:0] diff1;
  logic       ovf8, ovf1;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
`ifdef SERIAL_SUB_OVF_EN
    , .overflow(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
`ifdef SERIAL_SUB_OVF_EN
    , .overflow(ovf1)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic obs, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
    chk(tag, 32'(obs), 32'(exp));
`endif
  endtask

  // Waits (bounded) for done on the chosen instance; returns negedges waited.
  task automatic wait_done(input bit w1, output int lat);
    lat = 0;
    while (((w1 ? done1 : done8) !== 1'b1) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    string t;
    t = $sformatf("w8_%02h_%02h", ta, tb_v);
    @(negedge clk);
    a8 = ta; b8 = tb_v; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(1'b0, lat);
    chk({t, "_lat"}, 32'(lat), 32'd8);
    chk({t, "_diff"}, 32'(diff8), 32'(ed));
    chk({t, "_borrow"}, 32'(borrow8), 32'(eb));
    chk_ovf({t, "_ovf"}, ovf8, eo);
    @(negedge clk);
    chk({t, "_pulse"}, {busy8, done8}, 32'd0);
    $display("w8 a=%02h b=%02h diff=%02h borrow=%0d ovf=%0d lat=%0d", ta, tb_v, diff8, borrow8, ovf8, lat);
  endtask

  task automatic run1(input logic ta, input logic tb_v,
                      input logic ed, input logic eb, input logic eo);
    int lat;
    string t;
    t = $sformatf("w1_%0d_%0d", ta, tb_v);
    @(negedge clk);
    a1 = ta; b1 = tb_v; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b1, lat);
    chk({t, "_lat"}, 32'(lat), 32'd1);
    chk({t, "_diff"}, 32'(diff1), 32'(ed));
    chk({t, "_borrow"}, 32'(borrow1), 32'(eb));
    chk_ovf({t, "_ovf"}, ovf1, eo);
    $display("w1 a=%0d b=%0d diff=%0d borrow=%0d ovf=%0d lat=%0d", ta, tb_v, diff1, borrow1, ovf1, lat);
  endtask

  initial begin
    int lat;
    int pulses;
    int sa, sb, sd;
    logic [7:0] va, vb;

    rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_w8_outs", {busy8, done8, diff8, borrow8, ovf8}, 32'd0);
    chk("rst_w1_outs", {busy1, done1, diff1, borrow1, ovf1}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    run8(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    run8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run8(8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1);
    run8(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    run8(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

    // Back-to-back: start raised in DONE is ignored, accepted in the next IDLE cycle
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h12; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(1'b0, lat);
    chk("b2b_first_diff", 32'(diff8), 32'h23);
    a8 = 8'h44; b8 = 8'h04; start8 = 1'b1;
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    chk("b2b_accept_busy", 32'(busy8), 32'd1);
    start8 = 1'b0;
    wait_done(1'b0, lat);
    chk("b2b_lat", 32'(lat), 32'd8);
    chk("b2b_diff", 32'(diff8), 32'h40);
    $display("b2b second diff=%02h lat=%0d", diff8, lat);

    // start held high and a changed during RUN: one result, inputs ignored
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h12; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00;
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) pulses++;
      if (i == 8) begin
        chk("hold_done_at_8", 32'(done8), 32'd1);
        chk("hold_diff", 32'(diff8), 32'h23);
        start8 = 1'b0;
      end
    end
    chk("hold_pulses", 32'(pulses), 32'd1);
    $display("hold-start pulses=%0d diff=%02h", pulses, diff8);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("hold_diff_during_run", 32'(diff8), 32'h23);
    wait_done(1'b0, lat);
    chk("second_diff", 32'(diff8), 32'h0F);
    $display("second op diff=%02h", diff8);

    // Reset on the 4th RUN cycle aborts without a done pulse
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h12; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {busy8, done8, diff8, borrow8, ovf8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) pulses++;
    end
    chk("midrst_no_done", 32'(pulses), 32'd0);
    $display("mid-run reset: spurious activity=%0d", pulses);
    run8(8'h10, 8'h10, 8'h00, 1'b0, 1'b0);

    // WIDTH=1, all pairs
    run1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    run1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Sweep across the operand space against an arithmetic reference
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        va = 8'(ia * 17);
        vb = 8'(ib * 17) ^ 8'(ia);
        sa = int'($signed(va));
        sb = int'($signed(vb));
        sd = sa - sb;
        run8(va, vb, 8'(int'(va) - int'(vb)), (va < vb), (sd > 127 || sd < -128));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
